alu_muldiv_iter_exe: RTL and testbench
======================================

Name: alu_muldiv_iter_exe

Overview:
- Receiving end of the register-read → alu_muldiv issue path.
- Accepts one multiply/divide operation per handshake from the register read stage and computes it with an iterative radix-2 shift-add / restoring-divide datapath.
- Returns one result beat tagged with the physical destination and ROB index.
- Drives `busy` back to issue so that no new op is sent while an iteration is in flight.

Parameters:
- XLEN, 32, operand/result width
- PRF_IDX_W, 6, physical register tag width
- ROB_IDX_W, 5, ROB index width

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline kill; drops accepted or in-flight op
- in_valid  in  1  alu_muldiv pack valid from register read
- in_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_rs1  in  XLEN  source operand 1
- in_rs2  in  XLEN  source operand 2
- in_prd  in  PRF_IDX_W  physical destination tag
- in_rob  in  ROB_IDX_W  ROB index
- busy  out  1  unit cannot accept in_valid this cycle
- out_valid  out  1  result beat, single-cycle pulse
- out_data  out  XLEN  result
- out_prd  out  PRF_IDX_W  tag of result
- out_rob  out  ROB_IDX_W  ROB index of result

Behaviour:
- One clock, synchronous active-low reset.
- Reset values:
  - state=IDLE, busy=0, out_valid=0.
  - out_data, out_prd, out_rob and all internal registers = 0.
  - Reset mid-operation abandons the op silently.
- States are IDLE, CALC, DONE.
  - busy = (state==CALC).
  - out_valid = (state==DONE) && !flush.
- Accept:
  - in_valid is sampled in IDLE or DONE. Back-to-back issue is legal in the DONE cycle.
  - in_valid while busy is a protocol violation. Ignore it; a sim assertion fires.
- Normal path:
  - Accept cycle T → CALC for exactly XLEN cycles, counter 0..XLEN-1, wraps and exits at XLEN-1.
  - DONE at T+XLEN+1, so latency is 33 cycles at XLEN=32.
- Fast path (accept → DONE next cycle, latency 1):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow: DIV with rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000; REM in the same case → 0.
- Sign handling:
  - Signed operands are converted to magnitude at accept.
  - Signed operand means: rs1 for MULH/MULHSU/DIV/REM; rs2 for MULH/DIV/REM.
  - Unsigned core computes a 2·XLEN product, or quotient plus remainder.
  - Result negated at DONE entry:
    - product/quotient if signs differ;
    - remainder if dividend negative.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Multiply step: if multiplier LSB is set, add multiplicand to the upper accumulator (XLEN+1-bit carry); then shift the accumulator right 1.
- Divide step: shift remainder:quotient left 1; trial-subtract divisor. If non-negative, keep it and set quotient LSB=1.
- Tags: in_prd and in_rob are latched at accept and held stable through DONE.
- out_data, out_prd and out_rob hold their last value when out_valid=0.
- Flush:
  - Highest priority: state→IDLE next cycle.
  - Same-cycle in_valid is dropped.
  - DONE+flush emits no beat.
  - Flush in IDLE has no effect.
- No branch-mask tracking; kill granularity is the whole unit.

Decomposition:
- Falco_pkg gains:
  - `muldiv_op_t` enum, with the funct3 encodings above;
  - `muldiv_state_t` enum (IDLE/CALC/DONE).
- Also reuse the existing `int_issue_no_csr_pack_t`: the top-level wrapper unpacks `rs1/rs2/op/prd/rob` from it into the flat ports above.
- One sub-module: `muldiv_sign_adjust`, combinational.
  - Computes operand magnitude, final negation and the fast-path detect.
  - Instantiated once for pre-processing and once for post-processing.
- The FSM and the shared shift register stay in the top module.

Test Plan:
- MUL 7×6 → out_data=0x0000002A exactly 33 cycles after accept; busy high for 32 cycles; out_prd/out_rob echo inputs.
- MULH 0xFFFFFFFF(-1)×0x00000002 → 0xFFFFFFFF; MULHU same operands → 0x00000001; MULHSU 0x80000000×0xFFFFFFFF → 0x80000000.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV x/0 → 0xFFFFFFFF and REM 5/0 → 5, each with out_valid one cycle after accept; DIV 0x80000000/-1 → 0x80000000, REM → 0.
- flush at cycle 10 of CALC → no out_valid ever for that op; new op issued the next cycle completes normally. Flush during DONE → out_valid stays 0.
- Back-to-back: second in_valid in the DONE cycle of the first → two results 33 cycles apart. in_valid during CALC → assertion fires and the op is not executed.

Source files
------------

// File: rtl/alu_muldiv_iter_exe_pkg.sv
// Shared types for the iterative RV32M multiply/divide execute unit.
package alu_muldiv_iter_exe_pkg;

   localparam int DEF_XLEN      = 32;
   localparam int DEF_PRF_IDX_W = 6;
   localparam int DEF_ROB_IDX_W = 5;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   typedef struct packed {
      logic [DEF_XLEN-1:0]      rs1;
      logic [DEF_XLEN-1:0]      rs2;
      muldiv_op_t               op;
      logic [DEF_PRF_IDX_W-1:0] prd;
      logic [DEF_ROB_IDX_W-1:0] rob;
   } int_issue_no_csr_pack_t;

   function automatic logic op_signed_a(muldiv_op_t op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_signed_b(muldiv_op_t op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/alu_muldiv_iter_exe_sign_adjust.sv
// Operand magnitude, result negation and divide fast-path detect.
module muldiv_sign_adjust
   import alu_muldiv_iter_exe_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int W    = XLEN
) (
   input  muldiv_op_t       op,
   input  logic [W-1:0]     a,
   input  logic [XLEN-1:0]  b,
   input  logic             a_sgn,
   input  logic             b_sgn,
   output logic [W-1:0]     a_mag,
   output logic [XLEN-1:0]  b_mag,
   output logic [W-1:0]     q_adj,
   output logic [XLEN-1:0]  r_adj,
   output logic             fast,
   output logic [XLEN-1:0]  fast_data
);

   logic            neg_a;
   logic            neg_b;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] min_int;

   assign neg_a   = a_sgn && op_signed_a(op);
   assign neg_b   = b_sgn && op_signed_b(op);
   assign min_int = {1'b1, {(XLEN-1){1'b0}}};

   assign a_mag = neg_a ? -a : a;
   assign b_mag = neg_b ? -b : b;

   // a carries product/quotient, b carries remainder
   assign q_adj = (neg_a ^ neg_b) ? -a : a;
   assign r_adj = neg_a ? -b : b;

   assign div_zero = op[2] && (b == '0);
   assign ovf      = (op == OP_DIV || op == OP_REM)
                  && (a[XLEN-1:0] == min_int) && (&b);
   assign fast     = div_zero || ovf;

   always_comb begin
      fast_data = '0;
      if (div_zero)
         fast_data = op[1] ? a[XLEN-1:0] : '1;
      else if (ovf)
         fast_data = op[1] ? '0 : min_int;
   end

endmodule

// File: rtl/alu_muldiv_iter_exe.sv
// Iterative radix-2 RV32M execute unit: shift-add multiply,
// restoring divide, one tagged result beat per accepted op.
module alu_muldiv_iter_exe
   import alu_muldiv_iter_exe_pkg::*;
#(
   parameter int XLEN      = DEF_XLEN,
   parameter int PRF_IDX_W = DEF_PRF_IDX_W,
   parameter int ROB_IDX_W = DEF_ROB_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [2:0]           in_op,
   input  logic [XLEN-1:0]      in_rs1,
   input  logic [XLEN-1:0]      in_rs2,
   input  logic [PRF_IDX_W-1:0] in_prd,
   input  logic [ROB_IDX_W-1:0] in_rob,
   output logic                 busy,
   output logic                 out_valid,
   output logic [XLEN-1:0]      out_data,
   output logic [PRF_IDX_W-1:0] out_prd,
   output logic [ROB_IDX_W-1:0] out_rob
);

   localparam int CW = $clog2(XLEN);

   int_issue_no_csr_pack_t pk;
   muldiv_state_t          state, state_d;
   logic [CW-1:0]          cnt;
   logic [2*XLEN:0]        sr, sr_step;
   logic [XLEN-1:0]        opnd;
   muldiv_op_t             op_q;
   logic                   sa_q, sb_q;
   logic [PRF_IDX_W-1:0]   prd_q;
   logic [ROB_IDX_W-1:0]   rob_q;
   logic [XLEN-1:0]        data_q;
   logic [XLEN-1:0]        res;
   logic                   accept, last;

   logic [XLEN-1:0]        pre_a, pre_b, pre_fd;
   logic                   pre_fast;
   logic [XLEN-1:0]        pre_q_unused, pre_r_unused;
   logic [2*XLEN-1:0]      post_in, post_q;
   logic [XLEN-1:0]        post_r;
   logic [2*XLEN-1:0]      post_a_unused;
   logic [XLEN-1:0]        post_b_unused, post_fd_unused;
   logic                   post_fast_unused;

   assign pk = '{rs1: in_rs1, rs2: in_rs2, op: muldiv_op_t'(in_op),
                 prd: in_prd, rob: in_rob};

   assign accept = in_valid && !flush && (state != CALC);
   assign last   = (cnt == CW'(XLEN-1));

   muldiv_sign_adjust #(.XLEN(XLEN), .W(XLEN)) u_pre (
      .op(pk.op), .a(pk.rs1), .b(pk.rs2),
      .a_sgn(pk.rs1[XLEN-1]), .b_sgn(pk.rs2[XLEN-1]),
      .a_mag(pre_a), .b_mag(pre_b),
      .q_adj(pre_q_unused), .r_adj(pre_r_unused),
      .fast(pre_fast), .fast_data(pre_fd)
   );

   assign post_in = op_q[2] ? {{XLEN{1'b0}}, sr_step[XLEN-1:0]}
                            : sr_step[2*XLEN-1:0];

   muldiv_sign_adjust #(.XLEN(XLEN), .W(2*XLEN)) u_post (
      .op(op_q), .a(post_in), .b(sr_step[2*XLEN-1:XLEN]),
      .a_sgn(sa_q), .b_sgn(sb_q),
      .a_mag(post_a_unused), .b_mag(post_b_unused),
      .q_adj(post_q), .r_adj(post_r),
      .fast(post_fast_unused), .fast_data(post_fd_unused)
   );

   // one radix-2 step on the shared remainder:quotient / acc:multiplier
   always_comb begin
      logic [2*XLEN:0] sh;
      logic [XLEN:0]   diff;
      logic [XLEN:0]   hi;
      sh      = '0;
      diff    = '0;
      hi      = '0;
      sr_step = sr;
      if (op_q[2]) begin
         sh   = {sr[2*XLEN-1:0], 1'b0};
         diff = sh[2*XLEN:XLEN] - {1'b0, opnd};
         sr_step = diff[XLEN] ? sh : {diff, sh[XLEN-1:1], 1'b1};
      end else begin
         hi = {1'b0, sr[2*XLEN-1:XLEN]};
         if (sr[0])
            hi = hi + {1'b0, opnd};
         sr_step = {1'b0, hi, sr[XLEN-1:1]};
      end
   end

   always_comb begin
      res = '0;
      unique case (op_q)
         OP_MUL:                       res = post_q[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res = post_q[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              res = post_q[XLEN-1:0];
         OP_REM, OP_REMU:              res = post_r;
      endcase
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE, DONE: state_d = accept ? (pre_fast ? DONE : CALC) : IDLE;
         CALC:       if (last) state_d = DONE;
         default:    state_d = IDLE;
      endcase
      if (flush)
         state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         sr     <= '0;
         opnd   <= '0;
         op_q   <= OP_MUL;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         prd_q  <= '0;
         rob_q  <= '0;
         data_q <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            op_q  <= pk.op;
            sa_q  <= pk.rs1[XLEN-1];
            sb_q  <= pk.rs2[XLEN-1];
            prd_q <= pk.prd;
            rob_q <= pk.rob;
            cnt   <= '0;
            sr    <= {{(XLEN+1){1'b0}}, pk.op[2] ? pre_a : pre_b};
            opnd  <= pk.op[2] ? pre_b : pre_a;
            if (pre_fast)
               data_q <= pre_fd;
         end else if (state == CALC && !flush) begin
            sr  <= sr_step;
            cnt <= cnt + CW'(1);
            if (last)
               data_q <= res;
         end
      end
   end

   assign busy      = (state == CALC);
   assign out_valid = (state == DONE) && !flush;
   assign out_data  = data_q;
   assign out_prd   = prd_q;
   assign out_rob   = rob_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n)
         assert (!(in_valid && busy))
         else $warning("muldiv: in_valid while busy, op ignored");
   end
`endif

endmodule

// File: tb/tb_alu_muldiv_iter_exe.sv
// Directed bench for alu_muldiv_iter_exe: vector table plus
// hand-written flush / back-to-back / busy-issue sequences.
module tb_alu_muldiv_iter_exe;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid;
   logic [2:0]  in_op;
   logic [31:0] in_rs1, in_rs2;
   logic [5:0]  in_prd;
   logic [4:0]  in_rob;
   logic        busy, out_valid;
   logic [31:0] out_data;
   logic [5:0]  out_prd;
   logic [4:0]  out_rob;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2,
      MULHU = 3'd3, DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   alu_muldiv_iter_exe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_prd(in_prd), .in_rob(in_rob),
      .busy(busy), .out_valid(out_valid), .out_data(out_data),
      .out_prd(out_prd), .out_rob(out_rob)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] prd,
                        input logic [4:0] rob);
      in_valid = 1'b1;
      in_op    = op;
      in_rs1   = a;
      in_rs2   = b;
      in_prd   = prd;
      in_rob   = rob;
   endtask

   // called one negedge after issue; lat counts cycles since accept
   task automatic wait_out(output int lat, output int bcnt);
      lat  = 1;
      bcnt = 0;
      while (!out_valid && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt, seen;

      tbl.push_back('{MUL,    32'd7,        32'd6,        32'h0000002A, 33});
      tbl.push_back('{MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
      tbl.push_back('{MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001, 33});
      tbl.push_back('{MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
      tbl.push_back('{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33});
      tbl.push_back('{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
      tbl.push_back('{MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33});
      tbl.push_back('{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
      tbl.push_back('{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
      tbl.push_back('{DIVU,   32'd100,      32'd7,        32'd14,       33});
      tbl.push_back('{REMU,   32'd100,      32'd7,        32'd2,        33});
      tbl.push_back('{DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33});
      tbl.push_back('{REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33});
      tbl.push_back('{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33});
      tbl.push_back('{REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
      tbl.push_back('{DIV,    32'd1234,     32'd0,        32'hFFFFFFFF, 1});
      tbl.push_back('{REM,    32'd5,        32'd0,        32'd5,        1});
      tbl.push_back('{DIVU,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1});
      tbl.push_back('{REMU,   32'd7,        32'd0,        32'd7,        1});
      tbl.push_back('{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
      tbl.push_back('{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1});

      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_op = '0; in_rs1 = '0; in_rs2 = '0; in_prd = '0; in_rob = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_prd", 32'(out_prd), 32'd0);
      check("rst_rob", 32'(out_rob), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].a, tbl[i].b, 6'(i + 3), 5'(i));
         @(negedge clk);
         in_valid = 1'b0;
         wait_out(lat, bcnt);
         check($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
         check($sformatf("v%0d_data", i), out_data, tbl[i].exp);
         check($sformatf("v%0d_prd", i), 32'(out_prd), 32'(i + 3));
         check($sformatf("v%0d_rob", i), 32'(out_rob), 32'(i));
         check($sformatf("v%0d_busy", i), 32'(bcnt),
               32'(tbl[i].lat == 33 ? 32 : 0));
         @(negedge clk);
         check($sformatf("v%0d_pulse", i), 32'(out_valid), 32'd0);
      end

      // flush on cycle 10 of CALC, new op the cycle after
      drive(MUL, 32'd3, 32'd5, 6'd50, 5'd20);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1 check("calc_flush_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      check("calc_flush_idle", 32'(busy), 32'd0);
      drive(MUL, 32'd9, 32'd9, 6'h2A, 5'h15);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat, bcnt);
      check("post_flush_lat", 32'(lat), 32'd33);
      check("post_flush_data", out_data, 32'h51);
      check("post_flush_prd", 32'(out_prd), 32'h2A);
      check("post_flush_rob", 32'(out_rob), 32'h15);
      @(negedge clk);

      // flush in DONE suppresses the beat
      drive(DIV, 32'd1, 32'd0, 6'd1, 5'd1);
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b1;
      #1 check("done_flush_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1 check("done_flush_after", 32'(out_valid), 32'd0);
      check("done_flush_busy", 32'(busy), 32'd0);
      @(negedge clk);

      // back-to-back issue in the DONE cycle
      drive(MUL, 32'd7, 32'd6, 6'd11, 5'd3);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat, bcnt);
      check("b2b_first_lat", 32'(lat), 32'd33);
      check("b2b_first_data", out_data, 32'h2A);
      drive(DIVU, 32'd100, 32'd7, 6'd12, 5'd4);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat, bcnt);
      check("b2b_gap", 32'(lat), 32'd33);
      check("b2b_second_data", out_data, 32'd14);
      check("b2b_second_prd", 32'(out_prd), 32'd12);
      check("b2b_second_rob", 32'(out_rob), 32'd4);
      @(negedge clk);

      // in_valid during CALC must be ignored
      drive(MUL, 32'd2, 32'd3, 6'd5, 5'd5);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      drive(DIV, 32'd10, 32'd0, 6'd9, 5'd9);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat, bcnt);
      check("busy_issue_lat", 32'(lat + 5), 32'd33);
      check("busy_issue_data", out_data, 32'd6);
      check("busy_issue_prd", 32'(out_prd), 32'd5);
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      check("busy_issue_dropped", 32'(seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
